mram_burst_arbiter: RTL and testbench
=====================================

# mram_burst_arbiter

Shares the single MRAM burst address path between two requesters, such as a host read port and a host write port. It arbitrates between them round-robin, latches the winner's start address, length and direction, then steps the burst one beat per memory acknowledge. Address generation is internal: base address plus beat count, modulo 2^ADDR_WIDTH. It sits between the host-side request logic and the serial address/command path into the MRAM interface.

## Interface
- ADDR_WIDTH, 20, word address width
- LEN_WIDTH, 4, burst length field width; beats = len+1, so 1..2^LEN_WIDTH
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- req  input  2  per-requester request level; hold until granted
- req_addr0  input  ADDR_WIDTH  requester 0 start address
- req_len0  input  LEN_WIDTH  requester 0 length (0 = single transfer)
- req_we0  input  1  requester 0 direction (1 = write)
- req_addr1  input  ADDR_WIDTH  requester 1 start address
- req_len1  input  LEN_WIDTH  requester 1 length
- req_we1  input  1  requester 1 direction
- grant  output  2  one-hot, one-cycle pulse on acceptance
- owner  output  1  index of requester owning the current burst
- busy  output  1  high whenever state != IDLE
- mem_en  output  1  beat request to MRAM interface
- mem_we  output  1  direction of current burst
- mem_addr  output  ADDR_WIDTH  address of current beat
- mem_ack  input  1  MRAM accepted current beat
- beat_done  output  1  one-cycle pulse per accepted beat
- burst_done  output  1  one-cycle pulse after the last beat

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE:** `req` is sampled.
  - If any bit is set, the winner is chosen and the FSM moves to ISSUE.
  - If both bits are set, the requester != last_owner wins.
  - If one bit is set, that requester wins.
- **Acceptance (IDLE→ISSUE edge):**
  - latch base = req_addrN, len = req_lenN, we = req_weN
  - beat_cnt = 0, owner = N, last_owner = N
  - grant[N] = 1 for one cycle; mem_en = 1, mem_addr = base, mem_we = we
- **ISSUE:** mem_en holds until mem_ack = 1. On each edge with mem_ack = 1:
  - beat_done pulses.
  - If beat_cnt == len: go to DONE and set mem_en = 0.
  - Otherwise: beat_cnt += 1 and mem_addr = base + beat_cnt (new value), truncated to ADDR_WIDTH so it wraps 0xFFFFF → 0x00000.
- **DONE:** burst_done = 1 for one cycle, then go to IDLE.
- **Request handling:**
  - `req` is ignored while busy.
  - A requester that drops `req` before its grant is not served.
  - Inputs other than `req` are sampled only on the acceptance edge and may change afterwards.
- **mem_ack outside ISSUE:** ignored; no counter change and no pulse.
- **Reset (rst = 0 at an edge), including mid-burst:**
  - state = IDLE; grant, mem_en, mem_we, beat_done, burst_done, busy, owner = 0
  - mem_addr = 0, beat_cnt = 0
  - last_owner = 1, so requester 0 wins the first contention
  - An in-flight burst is dropped with no burst_done.

## Timing
- All outputs are registered.
- **Acceptance latency:** `req` high in IDLE at cycle N gives grant and mem_en high in cycle N+1.
- **Throughput:** with mem_ack tied high, one beat per cycle. A len = L burst occupies L+1 ISSUE cycles, then 1 DONE cycle.
- **Back-to-back bursts:** burst_done cycle, one IDLE cycle, then the next grant. The minimum gap between the last beat of one burst and the first beat of the next is 2 cycles of mem_en = 0.
- **Address timing:** mem_addr updates on the same edge that consumes mem_ack and is stable while mem_en = 1 and mem_ack = 0.
- **beat_done:** asserted the cycle after the acking edge, aligned with the next mem_addr.
- **burst_done:** asserted the cycle after the final beat_done.

## Test plan
- **Reset mid-burst:** rst = 0 during ISSUE → next cycle all outputs 0 and state IDLE. Then req = 2'b11 → grant = 2'b01.
- **Single transfer:** req0 with addr 0x00010, len 0, we 1, mem_ack high → one beat at 0x00010, mem_we = 1, then burst_done; beat_done count = 1.
- **Max burst with wrap:** req1 with addr 0xFFFFE, len 15, ack high → addresses 0xFFFFE, 0xFFFFF, 0x00000 … 0x0000D. 16 beat_done pulses, 16 consecutive mem_en cycles.
- **Backpressure:** len 2 with mem_ack low for 3 cycles before each beat → mem_addr held stable while waiting; three beats total; burst_done once.
- **Round-robin fairness:** both requesters hold req across 4 bursts → grant order 0, 1, 0, 1. 2-cycle mem_en gaps between bursts; owner matches each grant.
- **Request rules:** req0 asserted while busy, then dropped before the burst ends → never granted. Spurious mem_ack in IDLE → no beat_done.

Source files
------------

// File: rtl/mram_burst_arbiter.sv
// Round-robin arbiter for the shared MRAM burst address path.
// Latches the winning request and steps one beat per memory acknowledge.
module mram_burst_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [LEN_WIDTH-1:0]  req_len0,
    input  logic                  req_we0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [LEN_WIDTH-1:0]  req_len1,
    input  logic                  req_we1,
    output logic [1:0]            grant,
    output logic                  owner,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic                  beat_done,
    output logic                  burst_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t                state;
    logic                  last_owner;
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  nxt_cnt;

    logic                  win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic                  sel_we;

    assign nxt_cnt = beat_cnt + LEN_WIDTH'(1);

    // Pick the winner: on contention the requester that did not go last wins
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_owner;
        end
        sel_addr = win ? req_addr1 : req_addr0;
        sel_len  = win ? req_len1  : req_len0;
        sel_we   = win ? req_we1   : req_we0;
    end

    // Burst FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            base       <= '0;
            len        <= '0;
            beat_cnt   <= '0;
            beat_done  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            grant      <= 2'b00;
            beat_done  <= 1'b0;
            burst_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        base       <= sel_addr;
                        len        <= sel_len;
                        beat_cnt   <= '0;
                        owner      <= win;
                        last_owner <= win;
                        grant      <= win ? 2'b10 : 2'b01;
                        mem_en     <= 1'b1;
                        mem_we     <= sel_we;
                        mem_addr   <= sel_addr;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        beat_done <= 1'b1;
                        if (beat_cnt == len) begin
                            state  <= DONE;
                            mem_en <= 1'b0;
                        end else begin
                            beat_cnt <= nxt_cnt;
                            mem_addr <= base + ADDR_WIDTH'(nxt_cnt);
                        end
                    end
                end
                DONE: begin
                    burst_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mram_burst_arbiter.sv
// Scoreboard bench for mram_burst_arbiter.
// Expected beats and grants are queued at stimulus time and popped by a monitor.
module tb_mram_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [19:0] req_addr0, req_addr1;
    logic [3:0]  req_len0, req_len1;
    logic        req_we0, req_we1;
    logic [1:0]  grant;
    logic        owner, busy, mem_en, mem_we;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic        beat_done, burst_done;

    mram_burst_arbiter #(.ADDR_WIDTH(20), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_addr0(req_addr0), .req_len0(req_len0), .req_we0(req_we0),
        .req_addr1(req_addr1), .req_len1(req_len1), .req_we1(req_we1),
        .grant(grant), .owner(owner), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .beat_done(beat_done), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        o;
        logic        we;
        logic [19:0] a;
    } beat_t;

    beat_t exp_q[$];
    logic  gnt_q[$];

    int n_chk = 0;
    int n_fail = 0;

    int n_beat = 0, n_burst = 0, n_grant = 0;
    int en_run = 0, low_run = 0, last_run = 0;
    bit gap_chk = 0;
    bit ack_prev = 0, prev_en = 0, prev_ack = 0;
    logic [19:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [19:0] a, input logic [3:0] l,
                              input logic we, input logic o);
        beat_t e;
        for (int i = 0; i <= int'(l); i++) begin
            e.o  = o;
            e.we = we;
            e.a  = a + 20'(i);
            exp_q.push_back(e);
        end
        gnt_q.push_back(o);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        check("grant_timeout", n < 50, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!burst_done && n < 200) begin
            tick();
            n++;
        end
        check("done_timeout", n < 200, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en"}, mem_en, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_bdone"}, beat_done, 0);
        check({tag, "_burst"}, burst_done, 0);
    endtask

    // Monitor: scoreboard pops, beat_done alignment, address hold, run lengths
    always @(negedge clk) begin
        beat_t e;
        logic  o;
        if (rst) begin
            check("beat_done", beat_done, ack_prev);
            if (grant != 2'b00) begin
                n_grant++;
                if (gnt_q.size() == 0) begin
                    check("grant_unexp", grant, 0);
                end else begin
                    o = gnt_q.pop_front();
                    check("grant", grant, o ? 2'b10 : 2'b01);
                    check("owner", owner, o);
                end
            end
            if (prev_en && !prev_ack && mem_en)
                check("addr_hold", mem_addr, prev_addr);
            if (mem_en && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexp", mem_addr, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", mem_addr, e.a);
                    check("beat_we", mem_we, e.we);
                    check("beat_owner", owner, e.o);
                end
            end
            if (beat_done) n_beat++;
            if (burst_done) n_burst++;
        end
        if (mem_en) begin
            if (low_run > 0 && gap_chk) check("gap", low_run, 2);
            low_run = 0;
            en_run++;
        end else begin
            if (en_run > 0) last_run = en_run;
            en_run = 0;
            low_run++;
        end
        ack_prev  = rst && mem_en && mem_ack;
        prev_en   = rst && mem_en;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    initial begin
        int b0, u0, g0, gc, n;
        rst = 1'b0;
        req = 2'b00;
        mem_ack = 1'b0;
        req_addr0 = '0; req_len0 = '0; req_we0 = 1'b0;
        req_addr1 = '0; req_len1 = '0; req_we1 = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        // Single transfer
        b0 = n_beat; u0 = n_burst;
        req_addr0 = 20'h00010; req_len0 = 4'd0; req_we0 = 1'b1;
        mem_ack = 1'b1;
        push_burst(20'h00010, 4'd0, 1'b1, 1'b0);
        req = 2'b01;
        wait_grant();
        req = 2'b00;
        wait_done();
        tick();
        check("single_beats", n_beat - b0, 1);
        check("single_burst", n_burst - u0, 1);

        // Max burst with address wrap
        b0 = n_beat; u0 = n_burst;
        req_addr1 = 20'hFFFFE; req_len1 = 4'd15; req_we1 = 1'b0;
        push_burst(20'hFFFFE, 4'd15, 1'b0, 1'b1);
        req = 2'b10;
        wait_grant();
        req = 2'b00;
        wait_done();
        tick();
        check("wrap_beats", n_beat - b0, 16);
        check("wrap_run", last_run, 16);
        check("wrap_burst", n_burst - u0, 1);

        // Backpressure: three idle cycles before each beat
        b0 = n_beat; u0 = n_burst;
        req_addr1 = 20'h12345; req_len1 = 4'd2; req_we1 = 1'b1;
        mem_ack = 1'b0;
        push_burst(20'h12345, 4'd2, 1'b1, 1'b1);
        req = 2'b10;
        wait_grant();
        req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick(); tick(); tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        wait_done();
        tick();
        check("bp_beats", n_beat - b0, 3);
        check("bp_burst", n_burst - u0, 1);
        check("bp_run", last_run, 12);

        // Round-robin fairness with both requesters held
        u0 = n_burst;
        req_addr0 = 20'h00100; req_len0 = 4'd1; req_we0 = 1'b1;
        req_addr1 = 20'h00200; req_len1 = 4'd2; req_we1 = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_burst(20'h00100, 4'd1, 1'b1, 1'b0);
            push_burst(20'h00200, 4'd2, 1'b0, 1'b1);
        end
        req = 2'b11;
        gc = 0;
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (grant != 2'b00) gc++;
            else if (gc >= 1) gap_chk = 1;
            if (gc == 4) req = 2'b00;
            if (burst_done && gc == 4) break;
        end
        check("rr_timeout", n < 300, 1);
        tick();
        gap_chk = 0;
        check("rr_grants", gc, 4);
        check("rr_bursts", n_burst - u0, 4);

        // Request rules: req0 raised while busy then dropped; spurious ack
        g0 = n_grant;
        req_addr1 = 20'h00400; req_len1 = 4'd3; req_we1 = 1'b1;
        mem_ack = 1'b0;
        push_burst(20'h00400, 4'd3, 1'b1, 1'b1);
        req = 2'b10;
        wait_grant();
        req = 2'b01;
        tick(); tick(); tick();
        mem_ack = 1'b1;
        tick();
        req = 2'b00;
        wait_done();
        tick();
        b0 = n_beat;
        for (int k = 0; k < 5; k++) tick();
        check("rules_grants", n_grant - g0, 1);
        check("spur_beats", n_beat - b0, 0);
        check("spur_busy", busy, 0);

        // Reset mid-burst, then contention goes to requester 0
        u0 = n_burst;
        req_addr1 = 20'h00300; req_len1 = 4'd7; req_we1 = 1'b0;
        push_burst(20'h00300, 4'd7, 1'b0, 1'b1);
        req = 2'b10;
        wait_grant();
        req = 2'b00;
        tick(); tick();
        check("rst_pre_busy", busy, 1);
        rst = 1'b0;
        tick();
        check_zero("rst_mid");
        exp_q.delete();
        rst = 1'b1;
        req_addr0 = 20'h00500; req_len0 = 4'd1; req_we0 = 1'b0;
        push_burst(20'h00500, 4'd1, 1'b0, 1'b0);
        req = 2'b11;
        wait_grant();
        check("rst_rr_grant", grant, 2'b01);
        req = 2'b00;
        wait_done();
        tick();
        check("rst_bursts", n_burst - u0, 1);

        check("exp_q_empty", exp_q.size(), 0);
        check("gnt_q_empty", gnt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
